// File: rtl/blocpu_loader.sv
// Byte-stream program loader for the blocpu core: parses framed program words, writes them
// through the programming port, then pulses core reset and core run. Define
// BLOCPU_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module blocpu_loader #(
    parameter int         INSTRUCTION_WIDTH = 12,
    parameter int         ADDRESS_WIDTH     = 16,
    parameter logic [7:0] HEADER_BYTE       = 8'hB1
) (
    input  logic                         in_clock,
    input  logic                         in_reset_n,
    input  logic [7:0]                   in_byte,
    input  logic                         in_byte_valid,
    output logic                         out_byte_ready,
    input  logic                         in_clear,
    output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
    output logic [ADDRESS_WIDTH-1:0]     out_instruction_address,
    output logic                         out_instruction_write,
    output logic                         out_core_reset,
    output logic                         out_core_running,
    output logic                         out_busy,
    output logic                         out_done,
    output logic                         out_error
);

    // Upper instruction bits carried in the low part of the high byte.
    localparam int                       HI_BITS      = INSTRUCTION_WIDTH - 8;
    localparam logic [ADDRESS_WIDTH-1:0] ADDRESS_STEP = 1;

    // Encoding bits [7:3] are the busy/done/error/core_reset/core_run flags, so those
    // outputs come straight from the state flops; bits [2:0] only keep codes distinct.
    typedef enum logic [7:0] {
        IDLE        = 8'b0000_0000,
        LEN_HI      = 8'b1000_0001,
        LEN_LO      = 8'b1000_0010,
        INST_HI     = 8'b1000_0011,
        INST_LO     = 8'b1000_0100,
        WRITE       = 8'b1000_0101,
`ifdef BLOCPU_LOADER_CHECKSUM_EN
        CHECK       = 8'b1000_0110,
`endif
        START_RESET = 8'b1001_0000,
        START_RUN   = 8'b1000_1000,
        DONE        = 8'b0100_0000,
        ERROR       = 8'b0010_0000
    } state_t;

    state_t                   state;
    logic                     ready_q;
    logic                     write_q;
    logic                     write_phase;
    logic [7:0]               length_hi;
    logic [15:0]              words_left;
    logic [ADDRESS_WIDTH-1:0] next_address;
    logic [HI_BITS-1:0]       hi_bits;
`ifdef BLOCPU_LOADER_CHECKSUM_EN
    logic [7:0]               checksum;
`endif
    logic                     accept;
    logic                     is_header;

    // A clear in DONE wins over a header arriving in the same cycle, so no handshake then.
    assign out_byte_ready        = ready_q & ~(in_clear & out_done);
    assign accept                = in_byte_valid & out_byte_ready;
    assign is_header             = (in_byte == HEADER_BYTE);
    assign out_instruction_write = write_q;
    assign out_busy              = state[7];
    assign out_done              = state[6];
    assign out_error             = state[5];
    assign out_core_reset        = state[4];
    assign out_core_running      = state[3];

    // NOTE: every register here uses non-blocking assignment so all branches see pre-edge values.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state                   <= IDLE;
            ready_q                 <= 1'b0;
            write_q                 <= 1'b0;
            write_phase             <= 1'b0;
            length_hi               <= '0;
            words_left              <= '0;
            next_address            <= '0;
            hi_bits                 <= '0;
            out_instruction         <= '0;
            out_instruction_address <= '0;
`ifdef BLOCPU_LOADER_CHECKSUM_EN
            checksum                <= '0;
`endif
        end else begin
            write_q <= 1'b0;
            ready_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept && is_header) state <= LEN_HI;
                end
                LEN_HI: begin
                    if (accept) begin
                        length_hi <= in_byte;
`ifdef BLOCPU_LOADER_CHECKSUM_EN
                        checksum  <= in_byte;
`endif
                        state     <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        words_left   <= {length_hi, in_byte};
                        next_address <= '0;
`ifdef BLOCPU_LOADER_CHECKSUM_EN
                        checksum     <= checksum ^ in_byte;
`endif
                        if ({length_hi, in_byte} == 16'd0) begin
`ifdef BLOCPU_LOADER_CHECKSUM_EN
                            state   <= CHECK;
`else
                            state   <= START_RESET;
                            ready_q <= 1'b0;
`endif
                        end else begin
                            state <= INST_HI;
                        end
                    end
                end
                INST_HI: begin
                    if (accept) begin
                        if ((in_byte >> HI_BITS) != 8'd0) begin
                            state   <= ERROR;
                            ready_q <= 1'b0;
                        end else begin
                            hi_bits  <= in_byte[HI_BITS-1:0];
`ifdef BLOCPU_LOADER_CHECKSUM_EN
                            checksum <= checksum ^ in_byte;
`endif
                            state    <= INST_LO;
                        end
                    end
                end
                INST_LO: begin
                    if (accept) begin
                        // Word and address settle one cycle ahead of the strobe.
                        out_instruction         <= {hi_bits, in_byte};
                        out_instruction_address <= next_address;
`ifdef BLOCPU_LOADER_CHECKSUM_EN
                        checksum                <= checksum ^ in_byte;
`endif
                        write_phase             <= 1'b0;
                        state                   <= WRITE;
                        ready_q                 <= 1'b0;
                    end
                end
                WRITE: begin
                    if (!write_phase) begin
                        write_phase <= 1'b1;
                        write_q     <= 1'b1;
                        ready_q     <= 1'b0;
                    end else begin
                        write_phase  <= 1'b0;
                        next_address <= next_address + ADDRESS_STEP;
                        words_left   <= words_left - 16'd1;
                        if (words_left == 16'd1) begin
`ifdef BLOCPU_LOADER_CHECKSUM_EN
                            state   <= CHECK;
`else
                            state   <= START_RESET;
                            ready_q <= 1'b0;
`endif
                        end else begin
                            state <= INST_HI;
                        end
                    end
                end
`ifdef BLOCPU_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (accept) begin
                        state   <= (in_byte == checksum) ? START_RESET : ERROR;
                        ready_q <= 1'b0;
                    end
                end
`endif
                START_RESET: begin
                    state   <= START_RUN;
                    ready_q <= 1'b0;
                end
                START_RUN: begin
                    state <= DONE;
                end
                DONE: begin
                    if (in_clear)                state <= IDLE;
                    else if (accept && is_header) state <= LEN_HI;
                end
                ERROR: begin
                    if (in_clear) state <= IDLE;
                    else          ready_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blocpu_loader.sv
// Directed bench for blocpu_loader: a frame-level model predicts writes and core pulses,
// one compare process checks the programming port every cycle, literals pin the model.
`timescale 1ns/1ps
module tb_blocpu_loader;

    localparam logic [7:0] HDR = 8'hB1;

    logic        in_clock      = 1'b0;
    logic        in_reset_n    = 1'b1;
    logic [7:0]  in_byte       = 8'h00;
    logic        in_byte_valid = 1'b0;
    logic        in_clear      = 1'b0;
    logic        out_byte_ready;
    logic [11:0] out_instruction;
    logic [15:0] out_instruction_address;
    logic        out_instruction_write;
    logic        out_core_reset;
    logic        out_core_running;
    logic        out_busy;
    logic        out_done;
    logic        out_error;

    blocpu_loader dut (
        .in_clock                (in_clock),
        .in_reset_n              (in_reset_n),
        .in_byte                 (in_byte),
        .in_byte_valid           (in_byte_valid),
        .out_byte_ready          (out_byte_ready),
        .in_clear                (in_clear),
        .out_instruction         (out_instruction),
        .out_instruction_address (out_instruction_address),
        .out_instruction_write   (out_instruction_write),
        .out_core_reset          (out_core_reset),
        .out_core_running        (out_core_running),
        .out_busy                (out_busy),
        .out_done                (out_done),
        .out_error               (out_error)
    );

    always #5 in_clock = ~in_clock;

    typedef struct packed {
        logic [15:0] addr;
        logic [11:0] data;
    } wr_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    wr_t  exp_writes[$];
    wr_t  seen_writes[$];
    int   exp_pulses_total = 0;
    int   pulses_seen      = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Compare process: every cycle out of reset, check strobes and pulses against the model.
    logic        prev_write = 1'b0;
    logic [11:0] prev_instr = '0;
    logic [15:0] prev_addr  = '0;
    logic        run_due    = 1'b0;

    always @(negedge in_clock) begin
        if (!in_reset_n) begin
            prev_write <= 1'b0;
            run_due    <= 1'b0;
        end else begin
            if (out_instruction_write) begin
                wr_t w;
                check("write_single_cycle", prev_write, 1'b0);
                check("write_data_setup", prev_instr, out_instruction);
                check("write_addr_setup", prev_addr, out_instruction_address);
                check("write_ready_low", out_byte_ready, 1'b0);
                if (exp_writes.size() == 0) begin
                    check("write_unexpected", out_instruction_write, 1'b0);
                end else begin
                    w = exp_writes.pop_front();
                    check("write_data", out_instruction, w.data);
                    check("write_addr", out_instruction_address, w.addr);
                end
                seen_writes.push_back('{addr: out_instruction_address, data: out_instruction});
            end
            if (run_due) check("core_run_after_reset", out_core_running, 1'b1);
            else         check("core_run_spurious", out_core_running, 1'b0);
            if (out_core_reset) begin
                if (pulses_seen >= exp_pulses_total) check("core_reset_unexpected", out_core_reset, 1'b0);
                pulses_seen <= pulses_seen + 1;
            end
            check("status_exclusive", ($countones({out_busy, out_done, out_error}) <= 1), 1'b1);
            prev_write <= out_instruction_write;
            prev_instr <= out_instruction;
            prev_addr  <= out_instruction_address;
            run_due    <= out_core_reset;
        end
    end

    // Frame-level model: walks the byte stream by the frame rules; returns bytes consumed
    // and the outcome (0 idle, 1 done, 2 error, 3 mid-frame).
    task automatic model_stream(input logic [7:0] s[$], output int n_acc, output int outcome);
        int         i;
        int         len;
        logic [7:0] x;
        logic [7:0] hi;
        i       = 0;
        outcome = 0;
        while (i < s.size() && outcome != 2) begin
            if (s[i] != HDR) begin
                i++;
                continue;
            end
            len     = int'({s[i+1], s[i+2]});
            x       = s[i+1] ^ s[i+2];
            i      += 3;
            outcome = 3;
            for (int w = 0; w < len && outcome == 3; w++) begin
                hi = s[i];
                if (hi[7:4] != 4'h0) begin
                    outcome = 2;
                    i++;
                end else begin
                    exp_writes.push_back('{addr: 16'(w), data: {hi[3:0], s[i+1]}});
                    x = x ^ hi ^ s[i+1];
                    i += 2;
                end
            end
            if (outcome == 3) begin
`ifdef BLOCPU_LOADER_CHECKSUM_EN
                outcome = (s[i] == x) ? 1 : 2;
                i++;
`else
                outcome = 1;
`endif
                if (outcome == 1) exp_pulses_total++;
            end
        end
        n_acc = i;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        @(negedge in_clock);
        in_byte       = b;
        in_byte_valid = 1'b1;
        while (!out_byte_ready && waited < 40) begin
            @(negedge in_clock);
            waited++;
        end
        check("byte_accepted_in_time", out_byte_ready, 1'b1);
        @(posedge in_clock);
        #1;
        in_byte_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] s[$], output int outcome);
        int n_acc;
        model_stream(s, n_acc, outcome);
        for (int k = 0; k < n_acc; k++) send_byte(s[k]);
    endtask

    task automatic wait_outcome(input string name, input int outcome);
        int cyc;
        cyc = 0;
        while (!out_done && !out_error && cyc < 40) begin
            @(negedge in_clock);
            cyc++;
        end
        check({name, "_done"}, out_done, (outcome == 1));
        check({name, "_error"}, out_error, (outcome == 2));
        check({name, "_ready"}, out_byte_ready, (outcome == 1));
        check({name, "_busy"}, out_busy, 1'b0);
        check({name, "_writes_drained"}, exp_writes.size(), 0);
        check({name, "_pulse_count"}, pulses_seen, exp_pulses_total);
    endtask

    task automatic pulse_clear();
        @(negedge in_clock);
        in_clear = 1'b1;
        @(posedge in_clock);
        #1;
        in_clear = 1'b0;
        @(negedge in_clock);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ready"}, out_byte_ready, 1'b0);
        check({name, "_instr"}, out_instruction, 12'h000);
        check({name, "_addr"}, out_instruction_address, 16'h0000);
        check({name, "_flags"}, {out_instruction_write, out_core_reset, out_core_running,
                                  out_busy, out_done, out_error}, 6'b000000);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] s[$];
        int         outcome;
        int         base;
        int         pbase;

        #1 in_reset_n = 1'b0;
        repeat (3) @(negedge in_clock);
        check_all_zero("reset");
        in_reset_n = 1'b1;
        @(negedge in_clock);
        check("reset_release_ready", out_byte_ready, 1'b1);
        check("reset_release_busy", out_busy, 1'b0);

        // Two-word frame, core start sequence, DONE.
`ifdef BLOCPU_LOADER_CHECKSUM_EN
        s = {8'hB1, 8'h00, 8'h02, 8'h0A, 8'h05, 8'h08, 8'hFF, 8'hFA};
`else
        s = {8'hB1, 8'h00, 8'h02, 8'h0A, 8'h05, 8'h08, 8'hFF};
`endif
        base = seen_writes.size(); pbase = exp_pulses_total;
        send_stream(s, outcome);
        check("frame2_model_outcome", outcome, 1);
        wait_outcome("frame2", 1);
        check("frame2_nwrites", seen_writes.size() - base, 2);
        check("frame2_w0", {seen_writes[base].addr, seen_writes[base].data}, {16'h0000, 12'hA05});
        check("frame2_w1", {seen_writes[base+1].addr, seen_writes[base+1].data}, {16'h0001, 12'h8FF});
        check("frame2_pulses", exp_pulses_total - pbase, 1);

        // From DONE: junk byte discarded, header restarts; addresses restart at 0; hi nibble F legal.
`ifdef BLOCPU_LOADER_CHECKSUM_EN
        s = {8'h55, 8'hB1, 8'h00, 8'h01, 8'h0F, 8'h00, 8'h0E};
`else
        s = {8'h55, 8'hB1, 8'h00, 8'h01, 8'h0F, 8'h00};
`endif
        base = seen_writes.size();
        send_stream(s, outcome);
        wait_outcome("restart", 1);
        check("restart_w0", {seen_writes[base].addr, seen_writes[base].data}, {16'h0000, 12'hF00});

        // Clear in DONE beats a simultaneous header byte.
        @(negedge in_clock);
        in_clear = 1'b1; in_byte = HDR; in_byte_valid = 1'b1;
        @(posedge in_clock);
        #1;
        in_clear = 1'b0; in_byte_valid = 1'b0;
        @(negedge in_clock);
        check("clear_prio_busy", out_busy, 1'b0);
        check("clear_prio_done", out_done, 1'b0);
        check("clear_prio_ready", out_byte_ready, 1'b1);

`ifdef BLOCPU_LOADER_CHECKSUM_EN
        // Bad checksum: writes stand, no core pulses.
        s = {8'hB1, 8'h00, 8'h02, 8'h0A, 8'h05, 8'h08, 8'hFF, 8'hFB};
        base = seen_writes.size(); pbase = exp_pulses_total;
        send_stream(s, outcome);
        check("badchk_model_outcome", outcome, 2);
        wait_outcome("badchk", 2);
        check("badchk_nwrites", seen_writes.size() - base, 2);
        check("badchk_pulses", pulses_seen - pbase, 0);
        pulse_clear();
        check("badchk_clear_idle", {out_error, out_busy, out_byte_ready}, 3'b001);
`endif

        // High nibble set in an instruction high byte: ERROR, no write, stream stalls.
        s = {8'hB1, 8'h00, 8'h01, 8'h1A, 8'h05};
        base = seen_writes.size();
        send_stream(s, outcome);
        check("badhi_model_outcome", outcome, 2);
        wait_outcome("badhi", 2);
        @(negedge in_clock);
        in_byte = 8'h05; in_byte_valid = 1'b1;
        repeat (4) begin
            @(negedge in_clock);
            check("badhi_stall_ready", out_byte_ready, 1'b0);
        end
        in_byte_valid = 1'b0;
        check("badhi_nwrites", seen_writes.size() - base, 0);
        pulse_clear();
        check("badhi_clear_idle", {out_error, out_busy, out_byte_ready}, 3'b001);

        // Leading junk, zero-length frame; clear held high mid-frame is ignored.
`ifdef BLOCPU_LOADER_CHECKSUM_EN
        s = {8'h00, 8'hFF, 8'h3C, 8'hB1, 8'h00, 8'h00, 8'h00};
`else
        s = {8'h00, 8'hFF, 8'h3C, 8'hB1, 8'h00, 8'h00};
`endif
        base = seen_writes.size(); pbase = exp_pulses_total;
        in_clear = 1'b1;
        send_stream(s, outcome);
        in_clear = 1'b0;
        wait_outcome("zerolen", 1);
        check("zerolen_nwrites", seen_writes.size() - base, 0);
        check("zerolen_pulses", exp_pulses_total - pbase, 1);

        // Single word; without checksum no trailing byte is needed.
`ifdef BLOCPU_LOADER_CHECKSUM_EN
        s = {8'hB1, 8'h00, 8'h01, 8'h03, 8'h21, 8'h23};
`else
        s = {8'hB1, 8'h00, 8'h01, 8'h03, 8'h21};
`endif
        base = seen_writes.size();
        send_stream(s, outcome);
        wait_outcome("single", 1);
        check("single_w0", {seen_writes[base].addr, seen_writes[base].data}, {16'h0000, 12'h321});

        // Reset while waiting in INST_LO of word 1, then the full frame again.
        exp_writes.push_back('{addr: 16'h0000, data: 12'hA05});
        s = {8'hB1, 8'h00, 8'h02, 8'h0A, 8'h05, 8'h08};
        for (int k = 0; k < s.size(); k++) send_byte(s[k]);
        check("midreset_busy_before", out_busy, 1'b1);
        @(negedge in_clock);
        in_reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        check("midreset_write_seen", exp_writes.size(), 0);
        repeat (2) @(negedge in_clock);
        in_reset_n = 1'b1;
        @(negedge in_clock);
        check("midreset_release_ready", out_byte_ready, 1'b1);
`ifdef BLOCPU_LOADER_CHECKSUM_EN
        s = {8'hB1, 8'h00, 8'h02, 8'h0A, 8'h05, 8'h08, 8'hFF, 8'hFA};
`else
        s = {8'hB1, 8'h00, 8'h02, 8'h0A, 8'h05, 8'h08, 8'hFF};
`endif
        base = seen_writes.size();
        send_stream(s, outcome);
        wait_outcome("resend", 1);
        check("resend_w0", {seen_writes[base].addr, seen_writes[base].data}, {16'h0000, 12'hA05});
        check("resend_w1", {seen_writes[base+1].addr, seen_writes[base+1].data}, {16'h0001, 12'h8FF});

        repeat (3) @(negedge in_clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/blocpu_loader.md
BLOCPU_LOADER -- requirements
Module: blocpu_loader

Interface
REQ-001 SHALL have parameter INSTRUCTION_WIDTH, default 12: width of one program word.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 16: width of the program address.
REQ-003 SHALL have parameter HEADER_BYTE, default 8'hB1: frame start marker.
REQ-004 in_clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 in_reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_byte  input  8  incoming stream byte.
REQ-007 in_byte_valid  input  1  in_byte is valid; a byte transfers on a cycle with in_byte_valid and out_byte_ready both high.
REQ-008 out_byte_ready  output  1  loader can accept a byte.
REQ-009 in_clear  input  1  leave ERROR or DONE and return to IDLE.
REQ-010 out_instruction  output  INSTRUCTION_WIDTH  program word for the core programming port.
REQ-011 out_instruction_address  output  ADDRESS_WIDTH  target program address.
REQ-012 out_instruction_write  output  1  one-cycle write strobe.
REQ-013 out_core_reset  output  1  one-cycle core reset pulse.
REQ-014 out_core_running  output  1  one-cycle core start pulse.
REQ-015 out_busy, out_done, out_error  output  1 each  status flags.

Function
REQ-016 Frame format SHALL be: HEADER_BYTE, LEN_HI, LEN_LO, then N=LEN words of two bytes each (high byte first), then CHK (only when checksum is enabled).
REQ-017 States SHALL be IDLE, LEN_HI, LEN_LO, INST_HI, INST_LO, WRITE, CHECK, START_RESET, START_RUN, DONE and ERROR.
REQ-018 In IDLE, any byte other than HEADER_BYTE SHALL be accepted and discarded; HEADER_BYTE SHALL move the FSM to LEN_HI.
REQ-019 LEN_HI and LEN_LO SHALL capture N; N=0 SHALL go to CHECK (checksum enabled) or START_RESET (checksum disabled).
REQ-020 In INST_HI, a byte with bits [7:4] nonzero SHALL go to ERROR without a write; otherwise bits [3:0] SHALL be stored as instruction bits [11:8].
REQ-021 An INST_LO byte SHALL supply instruction bits [7:0] and move the FSM to WRITE.
REQ-022 In WRITE, the block SHALL hold out_instruction_write high for exactly one cycle; out_instruction and out_instruction_address SHALL be stable from the cycle before the strobe until the next write.
REQ-023 The address SHALL start at 0 and increment by 1 after each write; after write N the FSM SHALL go to CHECK or START_RESET, otherwise back to INST_HI.
REQ-024 out_byte_ready SHALL be high in IDLE, LEN_HI, LEN_LO, INST_HI, INST_LO, CHECK and DONE, and low in WRITE, START_RESET, START_RUN and ERROR.
REQ-025 START_RESET SHALL pulse out_core_reset for one cycle; START_RUN SHALL then pulse out_core_running for one cycle on the following cycle; the FSM SHALL then enter DONE.
REQ-026 out_busy SHALL be high in every state except IDLE, DONE and ERROR.
REQ-027 out_done SHALL be high only in DONE; out_error SHALL be high only in ERROR.
REQ-028 In DONE, a HEADER_BYTE SHALL start a new frame (go to LEN_HI); other bytes SHALL be discarded.
REQ-029 in_clear SHALL take priority over a simultaneous byte: DONE or ERROR goes to IDLE, and no byte is accepted that cycle.
REQ-030 in_clear SHALL be ignored in every state other than DONE and ERROR.
REQ-031 Writes already issued SHALL NOT be retracted on error.

Reset
REQ-032 Asserting in_reset_n low SHALL immediately force IDLE, clear the length, address, data and checksum registers, and drive all outputs to 0, including mid-frame.
REQ-033 After in_reset_n is released, out_byte_ready SHALL be 1 (IDLE).

Configuration
REQ-034 Macro BLOCPU_LOADER_CHECKSUM_EN defined: the frame SHALL end with CHK, where CHK equals the XOR of LEN_HI, LEN_LO and all word bytes (header excluded); a match SHALL go to START_RESET and a mismatch to ERROR.
REQ-035 BLOCPU_LOADER_CHECKSUM_EN undefined: there SHALL be no CHECK state and no CHK byte; after the last write the FSM SHALL go directly to START_RESET.

Verification (checksum enabled unless noted)
REQ-036 Bytes B1 00 02 0A 05 08 FF FA -> writes 0xA05@0x0000 and 0x8FF@0x0001; out_core_reset pulse, then out_core_running pulse on the next cycle; out_done=1.
REQ-037 Same frame with CHK=FB -> both writes occur; out_error=1; no core pulses; in_clear -> IDLE.
REQ-038 Bytes B1 00 01 1A 05 -> ERROR after byte 1A; no write strobe; out_byte_ready=0.
REQ-039 Bytes 00 FF 3C, then B1 00 00 00 -> leading bytes discarded; zero writes; both core pulses; out_done=1.
REQ-040 in_reset_n low during INST_LO of the REQ-036 frame -> all outputs 0 and IDLE; resending the full REQ-036 frame succeeds.
REQ-041 Macro undefined: bytes B1 00 01 03 21 -> write 0x321@0x0000, then core pulses with no CHK byte consumed.
